// File: rtl/muldiv_hilo_ctrl.sv
// muldiv_hilo_ctrl
//   Sequencer for the shared multiplier/divider and owner of the HI/LO
//   registers. Issues MULT/MULTU/DIV/DIVU to the Mult/Div units, holds their
//   operands stable, runs the validIn/validOut handshake, commits results to
//   HI/LO, serves MTHI/MTLO/MFHI/MFLO and stalls the core while an operation
//   is in flight.
//
// Parameters
//   WIDTH    datapath width of operands, HI and LO
//   TIMEOUT  cycles to wait for validOut before aborting (4..255)
//
// Ports
//   clk, reset_n                     clock (rising edge), async active-low reset
//   op_valid, op, srca, srcb, flush  core request (op encoding below) and abort
//   op_ready, stall, rd_data         handshake back to the core, MFHI/MFLO data
//   unit_a, unit_b                   latched operands shared by both units
//   mul_valid_in, mul_sign           Mult issue strobe (held) and signedness
//   mul_valid_out, mul_hi, mul_lo    Mult completion pulse and result
//   div_valid_in, div_sign           Div issue strobe (held) and signedness
//   div_valid_out, div_hi, div_lo    Div completion pulse, remainder, quotient
//   hi, lo                           architectural HI/LO registers
//   busy                             an operation is in flight
//   timeout_err                      sticky, set when a unit never answered
module muldiv_hilo_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             flush,
  output logic             op_ready,
  output logic             stall,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] unit_a,
  output logic [WIDTH-1:0] unit_b,
  output logic             mul_valid_in,
  output logic             mul_sign,
  input  logic             mul_valid_out,
  input  logic [WIDTH-1:0] mul_hi,
  input  logic [WIDTH-1:0] mul_lo,
  output logic             div_valid_in,
  output logic             div_sign,
  input  logic             div_valid_out,
  input  logic [WIDTH-1:0] div_hi,
  input  logic [WIDTH-1:0] div_lo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             timeout_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_WAIT = 2'd1,
    DIV_WAIT = 2'd2
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MFHI  = 3'b110;
  localparam logic [2:0] OP_MFLO  = 3'b111;

  // Last wait-counter value before the unit is declared dead.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t           state_q;
  logic [7:0]       cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] unit_a_q, unit_b_q;
  logic             mul_vin_q, div_vin_q;
  logic             mul_sign_q, div_sign_q;
  logic             terr_q;

  logic             accept_d;
  logic             cnt_last_d;
  logic [7:0]       cnt_d;

  // Ops are only taken in IDLE; a flush in the same cycle cancels the request.
  assign accept_d   = (state_q == IDLE) && op_valid && !flush;
  assign cnt_last_d = (cnt_q == CNT_LAST);
  assign cnt_d      = cnt_q + 8'd1;

  assign op_ready = accept_d;
  assign stall    = op_valid && !accept_d;

  // MFHI/MFLO return the pre-edge register value; anything else reads as 0.
  always_comb begin
    rd_data = '0;
    if (op_valid) begin
      if (op == OP_MFHI)      rd_data = hi_q;
      else if (op == OP_MFLO) rd_data = lo_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      unit_a_q   <= '0;
      unit_b_q   <= '0;
      mul_vin_q  <= 1'b0;
      div_vin_q  <= 1'b0;
      mul_sign_q <= 1'b0;
      div_sign_q <= 1'b0;
      terr_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                unit_a_q   <= srca;
                unit_b_q   <= srcb;
                mul_sign_q <= (op == OP_MULT);
                mul_vin_q  <= 1'b1;
                cnt_q      <= '0;
                state_q    <= MUL_WAIT;
              end
              OP_DIV, OP_DIVU: begin
                // Divide by zero is resolved here without engaging the unit.
                if (srcb == '0) begin
                  hi_q <= srca;
                  lo_q <= '1;
                end else begin
                  unit_a_q   <= srca;
                  unit_b_q   <= srcb;
                  div_sign_q <= (op == OP_DIV);
                  div_vin_q  <= 1'b1;
                  cnt_q      <= '0;
                  state_q    <= DIV_WAIT;
                end
              end
              OP_MTHI: hi_q <= srca;
              OP_MTLO: lo_q <= srca;
              default: ;
            endcase
          end
        end

        // Flush outranks a same-cycle completion; completion outranks timeout.
        MUL_WAIT: begin
          if (flush) begin
            mul_vin_q <= 1'b0;
            state_q   <= IDLE;
          end else if (mul_valid_out) begin
            hi_q      <= mul_hi;
            lo_q      <= mul_lo;
            mul_vin_q <= 1'b0;
            state_q   <= IDLE;
          end else if (cnt_last_d) begin
            mul_vin_q <= 1'b0;
            terr_q    <= 1'b1;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        DIV_WAIT: begin
          if (flush) begin
            div_vin_q <= 1'b0;
            state_q   <= IDLE;
          end else if (div_valid_out) begin
            hi_q      <= div_hi;
            lo_q      <= div_lo;
            div_vin_q <= 1'b0;
            state_q   <= IDLE;
          end else if (cnt_last_d) begin
            div_vin_q <= 1'b0;
            terr_q    <= 1'b1;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        default: begin
          mul_vin_q <= 1'b0;
          div_vin_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign unit_a       = unit_a_q;
  assign unit_b       = unit_b_q;
  assign mul_valid_in = mul_vin_q;
  assign mul_sign     = mul_sign_q;
  assign div_valid_in = div_vin_q;
  assign div_sign     = div_sign_q;
  assign hi           = hi_q;
  assign lo           = lo_q;
  assign busy         = (state_q != IDLE);
  assign timeout_err  = terr_q;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Testbench for muldiv_hilo_ctrl: table of single-cycle IDLE ops followed by
// hand-written sequences for multiply/divide handshakes, flush, timeout and reset.
module tb_muldiv_hilo_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         op_valid;
  logic [2:0]   op;
  logic [W-1:0] srca, srcb;
  logic         flush;
  logic         op_ready, stall;
  logic [W-1:0] rd_data, unit_a, unit_b;
  logic         mul_valid_in, mul_sign, mul_valid_out;
  logic [W-1:0] mul_hi, mul_lo;
  logic         div_valid_in, div_sign, div_valid_out;
  logic [W-1:0] div_hi, div_lo;
  logic [W-1:0] hi, lo;
  logic         busy, timeout_err;

  int checks = 0;
  int errors = 0;

  muldiv_hilo_ctrl #(.WIDTH(W), .TIMEOUT(8)) dut (
    .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op(op),
    .srca(srca), .srcb(srcb), .flush(flush), .op_ready(op_ready),
    .stall(stall), .rd_data(rd_data), .unit_a(unit_a), .unit_b(unit_b),
    .mul_valid_in(mul_valid_in), .mul_sign(mul_sign),
    .mul_valid_out(mul_valid_out), .mul_hi(mul_hi), .mul_lo(mul_lo),
    .div_valid_in(div_valid_in), .div_sign(div_sign),
    .div_valid_out(div_valid_out), .div_hi(div_hi), .div_lo(div_lo),
    .hi(hi), .lo(lo), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ov, input logic [2:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic fl);
    op_valid = ov; op = o; srca = a; srcb = b; flush = fl;
  endtask

  typedef struct {
    logic         ov;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         fl;
    logic         rdy, stl;
    logic [W-1:0] rd, hi, lo;
  } vec_t;

  vec_t tbl[9];
  int   cnt;

  initial begin
    tbl[0] = '{1'b1, 3'b100, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0,        32'hDEADBEEF, 32'h0};
    tbl[1] = '{1'b1, 3'b110, 32'h0,        32'h0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
    tbl[2] = '{1'b1, 3'b101, 32'h12345678, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0,        32'hDEADBEEF, 32'h12345678};
    tbl[3] = '{1'b1, 3'b111, 32'h0,        32'h0, 1'b0, 1'b1, 1'b0, 32'h12345678, 32'hDEADBEEF, 32'h12345678};
    tbl[4] = '{1'b1, 3'b011, 32'd100,      32'h0, 1'b0, 1'b1, 1'b0, 32'h0,        32'd100,      32'hFFFFFFFF};
    tbl[5] = '{1'b1, 3'b010, 32'hFFFFFFF0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0,        32'hFFFFFFF0, 32'hFFFFFFFF};
    tbl[6] = '{1'b1, 3'b100, 32'h55555555, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0,        32'hFFFFFFF0, 32'hFFFFFFFF};
    tbl[7] = '{1'b0, 3'b110, 32'h0,        32'h0, 1'b0, 1'b0, 1'b0, 32'h0,        32'hFFFFFFF0, 32'hFFFFFFFF};
    tbl[8] = '{1'b1, 3'b110, 32'h0,        32'h0, 1'b0, 1'b1, 1'b0, 32'hFFFFFFF0, 32'hFFFFFFF0, 32'hFFFFFFFF};

    reset_n = 1'b0;
    drive(1'b0, 3'b000, '0, '0, 1'b0);
    mul_valid_out = 1'b0; mul_hi = '0; mul_lo = '0;
    div_valid_out = 1'b0; div_hi = '0; div_lo = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", hi, '0);
    chk("rst_lo", lo, '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_terr", W'(timeout_err), '0);
    chk("rst_mvin", W'(mul_valid_in), '0);
    chk("rst_dvin", W'(div_valid_in), '0);
    @(negedge clk);
    reset_n = 1'b1;

    // Single-cycle ops from IDLE.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(tbl[i].ov, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].fl);
      #1;
      chk($sformatf("tbl%0d_ready", i), W'(op_ready), W'(tbl[i].rdy));
      chk($sformatf("tbl%0d_stall", i), W'(stall), W'(tbl[i].stl));
      chk($sformatf("tbl%0d_rd", i), rd_data, tbl[i].rd);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_hi", i), hi, tbl[i].hi);
      chk($sformatf("tbl%0d_lo", i), lo, tbl[i].lo);
      chk($sformatf("tbl%0d_busy", i), W'(busy), '0);
      chk($sformatf("tbl%0d_dvin", i), W'(div_valid_in), '0);
    end

    // MULT -3 * 7, result on wait cycle 5; MFLO waits behind it.
    @(negedge clk);
    drive(1'b1, 3'b000, 32'hFFFFFFFD, 32'd7, 1'b0);
    #1 chk("mult_ready", W'(op_ready), 32'd1);
    @(posedge clk); #1;
    chk("mult_vin", W'(mul_valid_in), 32'd1);
    chk("mult_sign", W'(mul_sign), 32'd1);
    chk("mult_a", unit_a, 32'hFFFFFFFD);
    chk("mult_b", unit_b, 32'd7);
    chk("mult_busy", W'(busy), 32'd1);
    cnt = 0;
    for (int w = 1; w <= 5; w++) begin
      @(negedge clk);
      drive(1'b1, 3'b111, '0, '0, 1'b0);
      mul_valid_out = (w == 5);
      mul_hi = 32'hFFFFFFFF; mul_lo = 32'hFFFFFFEB;
      div_valid_out = (w == 2);   // foreign unit, must be ignored
      div_hi = 32'h11111111; div_lo = 32'h22222222;
      #1 if (stall) cnt++;
      @(posedge clk);
    end
    @(negedge clk);
    mul_valid_out = 1'b0; div_valid_out = 1'b0;
    chk("mult_stall_cycles", W'(cnt), 32'd5);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFEB);
    chk("mult_done_busy", W'(busy), '0);
    chk("mult_done_vin", W'(mul_valid_in), '0);
    #1;
    chk("mflo_ready", W'(op_ready), 32'd1);
    chk("mflo_rd", rd_data, 32'hFFFFFFEB);
    @(posedge clk);

    // A completion pulse while IDLE is ignored.
    @(negedge clk);
    drive(1'b0, 3'b000, '0, '0, 1'b0);
    mul_valid_out = 1'b1; mul_hi = 32'h12341234; mul_lo = 32'h56785678;
    @(posedge clk); #1;
    chk("idle_pulse_hi", hi, 32'hFFFFFFFF);
    chk("idle_pulse_lo", lo, 32'hFFFFFFEB);
    chk("idle_pulse_busy", W'(busy), '0);
    @(negedge clk);
    mul_valid_out = 1'b0;

    // DIV -7 / 4 in flight, MFLO stalls until commit.
    drive(1'b1, 3'b010, 32'hFFFFFFF9, 32'd4, 1'b0);
    @(posedge clk); #1;
    chk("div_vin", W'(div_valid_in), 32'd1);
    chk("div_sign", W'(div_sign), 32'd1);
    cnt = 0;
    for (int w = 1; w <= 3; w++) begin
      @(negedge clk);
      drive(1'b1, 3'b111, '0, '0, 1'b0);
      div_valid_out = (w == 3);
      div_hi = 32'hFFFFFFFD; div_lo = 32'hFFFFFFFF;
      #1 if (stall) cnt++;
      @(posedge clk);
    end
    @(negedge clk);
    div_valid_out = 1'b0;
    chk("div_stall_cycles", W'(cnt), 32'd3);
    chk("div_hi", hi, 32'hFFFFFFFD);
    chk("div_lo", lo, 32'hFFFFFFFF);
    #1 chk("div_mflo_rd", rd_data, 32'hFFFFFFFF);
    @(posedge clk);

    // DIVU with flush landing on the same cycle as div_valid_out.
    @(negedge clk);
    drive(1'b1, 3'b011, 32'd50, 32'd5, 1'b0);
    @(posedge clk); #1;
    chk("divu_sign", W'(div_sign), '0);
    @(negedge clk);
    drive(1'b0, 3'b000, '0, '0, 1'b0);
    @(negedge clk);
    drive(1'b0, 3'b000, '0, '0, 1'b1);
    div_valid_out = 1'b1; div_hi = 32'h0; div_lo = 32'd10;
    @(posedge clk); #1;
    chk("flush_hi", hi, 32'hFFFFFFFD);
    chk("flush_lo", lo, 32'hFFFFFFFF);
    chk("flush_busy", W'(busy), '0);
    chk("flush_dvin", W'(div_valid_in), '0);
    @(negedge clk);
    div_valid_out = 1'b0;
    drive(1'b1, 3'b110, '0, '0, 1'b0);
    #1 chk("flush_next_ready", W'(op_ready), 32'd1);

    // MULTU with a silent unit: abort after 8 wait cycles.
    @(negedge clk);
    drive(1'b1, 3'b001, 32'd3, 32'd4, 1'b0);
    @(posedge clk); #1;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (!busy) break;
      cnt++;
      @(negedge clk);
      drive(1'b0, 3'b000, '0, '0, 1'b0);
      @(posedge clk); #1;
    end
    chk("to_wait_cycles", W'(cnt), 32'd8);
    chk("to_err", W'(timeout_err), 32'd1);
    chk("to_mvin", W'(mul_valid_in), '0);
    chk("to_hi", hi, 32'hFFFFFFFD);
    chk("to_lo", lo, 32'hFFFFFFFF);

    // Reset pulse in the middle of a MULT clears everything at once.
    @(negedge clk);
    drive(1'b1, 3'b000, 32'd9, 32'd9, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 3'b000, '0, '0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("arst_busy", W'(busy), '0);
    chk("arst_mvin", W'(mul_valid_in), '0);
    chk("arst_sign", W'(mul_sign), '0);
    chk("arst_a", unit_a, '0);
    chk("arst_hi", hi, '0);
    chk("arst_lo", lo, '0);
    chk("arst_terr", W'(timeout_err), '0);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_busy", W'(busy), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
